// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its serial parameter loader:
// state encoding, leak amounts and power-on parameter defaults.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    INTEGRATE  = 2'b01,
    REFRACTORY = 2'b10
  } lif_state_e;

  localparam logic [7:0] LEAK_0 = 8'd0;
  localparam logic [7:0] LEAK_1 = 8'd1;
  localparam logic [7:0] LEAK_2 = 8'd2;
  localparam logic [7:0] LEAK_3 = 8'd4;

  localparam logic [2:0] DEFAULT_WEIGHT      = 3'd1;
  localparam logic [1:0] DEFAULT_LEAK_CONFIG = 2'd0;
  localparam logic [7:0] DEFAULT_THRESHOLD   = 8'd64;

  function automatic logic [7:0] leak_amount(input logic [1:0] cfg);
    case (cfg)
      2'd0:    leak_amount = LEAK_0;
      2'd1:    leak_amount = LEAK_1;
      2'd2:    leak_amount = LEAK_2;
      default: leak_amount = LEAK_3;
    endcase
  endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane step: leak with floor at 0, add the weighted event,
// saturate to 8 bits and decide whether the result fires.
module lif_membrane_update
  import lif_pkg::*;
(
  input  logic [7:0] membrane,
  input  logic       spike_in,
  input  logic [2:0] weight,
  input  logic [1:0] leak_config,
  input  logic [7:0] threshold,
  output logic [7:0] next_membrane,
  output logic       fire
);

  function automatic logic [7:0] sub_floor(input logic [7:0] a, input logic [7:0] b);
    sub_floor = (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] sat8(input logic [8:0] v);
    sat8 = v[8] ? 8'hFF : v[7:0];
  endfunction

  logic [7:0] leaked;
  logic [8:0] sum;

  always_comb begin
    leaked        = sub_floor(membrane, leak_amount(leak_config));
    sum           = {1'b0, leaked} + {6'd0, (spike_in ? weight : 3'd0)};
    next_membrane = sat8(sum);
    // The non-zero guard keeps threshold=0 from firing a neuron at rest.
    fire          = (next_membrane >= threshold) && (next_membrane != 8'd0);
  end

endmodule

// File: rtl/lif_neuron_core.sv
// Single leaky-integrate-and-fire neuron: state machine, membrane register,
// refractory counter and saturating spike counter.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int REFRACT_CYCLES = 4,
  parameter int SPIKE_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   spike_in,
  input  logic [2:0]             weight,
  input  logic [1:0]             leak_config,
  input  logic [7:0]             threshold,
  input  logic                   params_ready,
  output logic [7:0]             membrane,
  output logic                   spike_out,
  output logic                   refractory,
  output logic [SPIKE_CNT_W-1:0] spike_count
);

  localparam logic [3:0] REFRACT_LOAD = 4'(REFRACT_CYCLES);

  lif_state_e             state, state_nxt;
  logic [7:0]             membrane_nxt;
  logic                   spike_out_nxt;
  logic [SPIKE_CNT_W-1:0] spike_count_nxt;
  logic [3:0]             rcnt, rcnt_nxt;
  logic [7:0]             upd_membrane;
  logic                   upd_fire;

  lif_membrane_update u_update (
    .membrane      (membrane),
    .spike_in      (spike_in),
    .weight        (weight),
    .leak_config   (leak_config),
    .threshold     (threshold),
    .next_membrane (upd_membrane),
    .fire          (upd_fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      membrane    <= 8'd0;
      spike_out   <= 1'b0;
      spike_count <= '0;
      rcnt        <= 4'd0;
    end else begin
      state       <= state_nxt;
      membrane    <= membrane_nxt;
      spike_out   <= spike_out_nxt;
      spike_count <= spike_count_nxt;
      rcnt        <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    membrane_nxt    = membrane;
    spike_out_nxt   = 1'b0;
    spike_count_nxt = spike_count;
    rcnt_nxt        = rcnt;

    if (enable) begin
      // A parameter reload wins over everything, including a fire this cycle.
      if (!params_ready) begin
        state_nxt       = IDLE;
        membrane_nxt    = 8'd0;
        spike_count_nxt = '0;
        rcnt_nxt        = 4'd0;
      end else begin
        case (state)
          IDLE: begin
            state_nxt    = INTEGRATE;
            membrane_nxt = 8'd0;
          end
          INTEGRATE: begin
            if (upd_fire) begin
              membrane_nxt  = 8'd0;
              spike_out_nxt = 1'b1;
              if (spike_count != '1)
                spike_count_nxt = spike_count + SPIKE_CNT_W'(1);
              if (REFRACT_CYCLES != 0) begin
                state_nxt = REFRACTORY;
                rcnt_nxt  = REFRACT_LOAD;
              end
            end else begin
              membrane_nxt = upd_membrane;
            end
          end
          REFRACTORY: begin
            membrane_nxt = 8'd0;
            if (rcnt <= 4'd1) begin
              state_nxt = INTEGRATE;
              rcnt_nxt  = 4'd0;
            end else begin
              rcnt_nxt = rcnt - 4'd1;
            end
          end
          default: begin
            state_nxt    = IDLE;
            membrane_nxt = 8'd0;
            rcnt_nxt     = 4'd0;
          end
        endcase
      end
    end
  end

  assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Bench for lif_neuron_core: vector table, directed corner sequences and
// randomized stimulus against an integer reference model.
module tb_lif_neuron_core;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic [2:0] weight = 3'd0;
  logic [1:0] leak_config = 2'd0;
  logic [7:0] threshold = 8'd0;
  logic       params_ready = 1'b0;
  logic [7:0] membrane;
  logic       spike_out;
  logic       refractory;
  logic [7:0] spike_count;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 integrating, 2 refractory
  int m_phase, m_mem, m_cnt, m_left;
  bit m_spk;

  lif_neuron_core #(.REFRACT_CYCLES(R), .SPIKE_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .spike_in     (spike_in),
    .weight       (weight),
    .leak_config  (leak_config),
    .threshold    (threshold),
    .params_ready (params_ready),
    .membrane     (membrane),
    .spike_out    (spike_out),
    .refractory   (refractory),
    .spike_count  (spike_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mem = 0; m_cnt = 0; m_left = 0; m_spk = 0;
  endtask

  task automatic model_step(input bit en, input bit sin, input int w, input int lc,
                            input int th, input bit pr);
    int leak, nx;
    m_spk = 0;
    if (!en) return;
    if (!pr) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      leak = (lc == 3) ? 4 : lc;
      nx = m_mem - leak;
      if (nx < 0) nx = 0;
      if (sin) nx = nx + w;
      if (nx > 255) nx = 255;
      if (nx >= th && nx != 0) begin
        m_mem = 0;
        m_spk = 1;
        if (m_cnt < 255) m_cnt++;
        if (R > 0) begin
          m_phase = 2;
          m_left = R;
        end
      end else begin
        m_mem = nx;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_phase = 1;
    end
  endtask

  task automatic check_model();
    check("membrane", membrane, m_mem);
    check("spike_out", spike_out, m_spk);
    check("refractory", refractory, (m_phase == 2));
    check("spike_count", spike_count, m_cnt);
  endtask

  task automatic step(input bit en, input bit sin, input int w, input int lc,
                      input int th, input bit pr);
    enable = en; spike_in = sin; weight = 3'(w); leak_config = 2'(lc);
    threshold = 8'(th); params_ready = pr;
    @(posedge clk); #1;
    model_step(en, sin, w, lc, th, pr);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; spike_in = 1'b1; params_ready = 1'b1;
    weight = 3'd7; threshold = 8'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("rst_membrane", membrane, 0);
    check("rst_spike_out", spike_out, 0);
    check("rst_refractory", refractory, 0);
    check("rst_spike_count", spike_count, 0);
  endtask

  typedef struct {
    bit sin; int w; int lc; int th;
    int mem; bit spk; bit refr; int cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 3, 1, 10, 0, 0, 0, 0};
    vecs[1]  = '{1, 3, 1, 10, 3, 0, 0, 0};
    vecs[2]  = '{1, 3, 1, 10, 5, 0, 0, 0};
    vecs[3]  = '{1, 3, 1, 10, 7, 0, 0, 0};
    vecs[4]  = '{1, 3, 1, 10, 9, 0, 0, 0};
    vecs[5]  = '{1, 3, 1, 10, 0, 1, 1, 1};
    vecs[6]  = '{1, 3, 1, 10, 0, 0, 1, 1};
    vecs[7]  = '{1, 3, 1, 10, 0, 0, 1, 1};
    vecs[8]  = '{1, 3, 1, 10, 0, 0, 1, 1};
    vecs[9]  = '{1, 3, 1, 10, 0, 0, 0, 1};
    vecs[10] = '{1, 3, 1, 10, 3, 0, 0, 1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // leak 1, weight 3, threshold 10 through fire and refractory
    foreach (vecs[i]) begin
      step(1, vecs[i].sin, vecs[i].w, vecs[i].lc, vecs[i].th, 1);
      check($sformatf("vec%0d_membrane", i), membrane, vecs[i].mem);
      check($sformatf("vec%0d_spike_out", i), spike_out, vecs[i].spk);
      check($sformatf("vec%0d_refractory", i), refractory, vecs[i].refr);
      check($sformatf("vec%0d_spike_count", i), spike_count, vecs[i].cnt);
    end

    // weight 2, threshold 30: fires on the 15th event
    do_reset();
    step(1, 0, 2, 0, 30, 1);
    for (int i = 1; i <= 14; i++) begin
      step(1, 1, 2, 0, 30, 1);
      check("ramp_membrane", membrane, 2 * i);
    end
    step(1, 1, 2, 0, 30, 1);
    check("ramp_fire", spike_out, 1);
    check("ramp_fire_membrane", membrane, 0);
    check("ramp_fire_count", spike_count, 1);
    step(0, 1, 2, 0, 30, 1);
    check("pulse_not_stretched", spike_out, 0);
    check("refr_held_when_disabled", refractory, 1);

    // saturation at 255 instead of wrapping
    do_reset();
    step(1, 0, 7, 0, 255, 1);
    for (int i = 1; i <= 36; i++) step(1, 1, 7, 0, 255, 1);
    check("sat_membrane_252", membrane, 252);
    step(1, 1, 7, 0, 255, 1);
    check("sat_fire", spike_out, 1);
    check("sat_fire_membrane", membrane, 0);

    // leak 3 decay from 20, then threshold 0 at rest
    do_reset();
    step(1, 0, 5, 0, 255, 1);
    repeat (4) step(1, 1, 5, 0, 255, 1);
    check("decay_start", membrane, 20);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 5, 3, 255, 1);
      check("decay_membrane", membrane, (i < 5) ? 16 - 4 * i : 0);
      check("decay_no_spike", spike_out, 0);
    end
    repeat (3) begin
      step(1, 0, 5, 3, 0, 1);
      check("th0_rest_no_spike", spike_out, 0);
    end
    step(1, 1, 1, 0, 0, 1);
    check("th0_event_fires", spike_out, 1);

    // reload: params_ready low clears membrane and count
    do_reset();
    step(1, 0, 5, 0, 5, 1);
    repeat (3) begin
      step(1, 1, 5, 0, 5, 1);
      repeat (R) step(1, 0, 5, 0, 5, 1);
    end
    repeat (4) step(1, 1, 5, 0, 200, 1);
    check("reload_pre_membrane", membrane, 20);
    check("reload_pre_count", spike_count, 3);
    step(1, 1, 7, 0, 1, 0);
    check("reload_membrane", membrane, 0);
    check("reload_count", spike_count, 0);
    check("reload_no_fire", spike_out, 0);
    repeat (3) step(1, 1, 7, 0, 200, 0);
    check("reload_ignored", membrane, 0);
    step(1, 1, 5, 0, 200, 1);
    check("reload_idle_exit", membrane, 0);
    step(1, 1, 5, 0, 200, 1);
    check("reload_restart", membrane, 5);

    // reset during the 2nd refractory cycle
    step(1, 1, 7, 0, 1, 1);
    check("pre_reset_fire", spike_out, 1);
    step(1, 1, 7, 0, 1, 1);
    do_reset();
    check("post_reset_refr", refractory, 0);

    // enable low freezes an integrating neuron
    step(1, 0, 3, 0, 100, 1);
    repeat (2) step(1, 1, 3, 0, 100, 1);
    repeat (5) begin
      step(0, 1, 3, 0, 100, 1);
      check("frozen_membrane", membrane, 6);
      check("frozen_spike", spike_out, 0);
    end

    // spike counter saturates at all-ones
    do_reset();
    step(1, 0, 1, 0, 1, 1);
    repeat (260 * (R + 1)) step(1, 1, 1, 0, 1, 1);
    check("count_saturated", spike_count, 255);

    // randomized against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40),
           ($urandom_range(0, 15) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
